soc_bus_initiator: RTL and testbench

//  Memory-bus master that drives the fixed-latency peripheral register bus (the side GPIO/peripheral

---
 rtl/soc_bus_initiator_if.sv | 39 +++
 rtl/soc_bus_initiator.sv | 108 ++++++++++
 tb/tb_soc_bus_initiator.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/soc_bus_initiator_if.sv
// Command, response and peripheral-bus signals of the register-bus initiator.
// The master modport is the initiator's view; slave is the sequencer/responder side.
interface soc_bus_initiator_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_type;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_we;
    logic [31:0] rsp_rdata;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_type, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_we, rsp_rdata,
        input  rsp_ready,
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_type, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_we, rsp_rdata,
        output rsp_ready,
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata
    );
endinterface

// File: rtl/soc_bus_initiator.sv
// Single-outstanding master for the fixed-latency peripheral register bus:
// one command in, one bus request out, read data captured BUS_LATENCY cycles later.
module soc_bus_initiator #(
    parameter int BUS_LATENCY = 1   // 1..15, must match the responders
) (
    input  logic                clk,
    input  logic                res_n,
    soc_bus_initiator_if.master ifc,
    output logic                busy
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_cmd_t;

    localparam logic [3:0] CNT_LOAD = 4'(BUS_LATENCY - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    bus_cmd_t    r_bus;
    logic        r_rsp_we;
    logic [31:0] r_rsp_rdata;
    logic        w_accept;
    logic        w_sample;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_accept      = 1'b0;
        w_sample      = 1'b0;
        ifc.cmd_ready = 1'b0;
        ifc.bus_req   = 1'b0;
        ifc.rsp_valid = 1'b0;
        busy          = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                ifc.cmd_ready = 1'b1;
                busy          = 1'b0;
                if (ifc.cmd_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_REQ;
                end
            end
            S_REQ: begin
                ifc.bus_req = 1'b1;
                w_next      = S_WAIT;
            end
            S_WAIT: begin
                // counter reaches 0 exactly in request cycle + BUS_LATENCY
                if (r_cnt == 4'd0) begin
                    w_sample = 1'b1;
                    w_next   = S_RESP;
                end
            end
            S_RESP: begin
                ifc.rsp_valid = 1'b1;
                if (ifc.rsp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_cnt <= 4'd0;
        end else if (r_state == S_REQ) begin
            r_cnt <= CNT_LOAD;
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Bus fields stay registered for the whole transaction; type lands in addr[3:2]
    // so SET/CLR/INV reach the alias registers.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_bus <= '0;
        end else if (w_accept) begin
            r_bus.we    <= ifc.cmd_we;
            r_bus.addr  <= {ifc.cmd_addr[31:4], ifc.cmd_type, 2'b00};
            r_bus.wdata <= ifc.cmd_wdata;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_rsp_we    <= 1'b0;
            r_rsp_rdata <= 32'd0;
        end else if (w_sample) begin
            r_rsp_we    <= r_bus.we;
            r_rsp_rdata <= r_bus.we ? 32'd0 : ifc.bus_rdata;
        end
    end

    assign ifc.bus_we    = r_bus.we;
    assign ifc.bus_addr  = r_bus.addr;
    assign ifc.bus_wdata = r_bus.wdata;
    assign ifc.rsp_we    = r_rsp_we;
    assign ifc.rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_soc_bus_initiator.sv
// Drives four initiators (latency 1, 2, 3, 15) from shared command/response stimulus and
// checks each against a transaction-level timing model.
module tb_soc_bus_initiator;
    logic        clk = 1'b0;
    logic        res_n;
    logic        cmd_valid;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_type;
    logic [31:0] cmd_wdata;
    logic        rsp_ready;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 15;

        soc_bus_initiator_if ifc ();
        logic busy;

        assign ifc.cmd_valid = cmd_valid;
        assign ifc.cmd_we    = cmd_we;
        assign ifc.cmd_addr  = cmd_addr;
        assign ifc.cmd_type  = cmd_type;
        assign ifc.cmd_wdata = cmd_wdata;
        assign ifc.rsp_ready = rsp_ready;

        soc_bus_initiator #(.BUS_LATENCY(L)) u_dut (
            .clk   (clk),
            .res_n (res_n),
            .ifc   (ifc),
            .busy  (busy)
        );

        // responder: fresh random read data every cycle, so a mistimed sample is caught
        initial begin
            ifc.bus_rdata = $urandom;
            forever begin
                @(posedge clk); #1;
                ifc.bus_rdata = $urandom;
            end
        end

        // model: age counts cycles since the accepting cycle (age 0)
        bit          act;
        int          age;
        logic        m_we, m_rwe;
        logic [31:0] m_addr, m_wdata, m_rdata;
        int          nrsp;

        initial begin
            act = 0; age = 0; nrsp = 0;
            m_we = 0; m_rwe = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
            forever begin
                @(negedge clk);
                if (!res_n) begin
                    act = 0; m_we = 0; m_rwe = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
                end else if (act) begin
                    age++;
                end
                chk($sformatf("L%0d bus_req", L),   32'(ifc.bus_req),   32'(act && age == 1));
                chk($sformatf("L%0d cmd_ready", L), 32'(ifc.cmd_ready), 32'(!act));
                chk($sformatf("L%0d rsp_valid", L), 32'(ifc.rsp_valid), 32'(act && age >= L + 2));
                chk($sformatf("L%0d busy", L),      32'(busy),          32'(act));
                chk($sformatf("L%0d bus_addr", L),  ifc.bus_addr,       m_addr);
                chk($sformatf("L%0d bus_we", L),    32'(ifc.bus_we),    32'(m_we));
                chk($sformatf("L%0d bus_wdata", L), ifc.bus_wdata,      m_wdata);
                chk($sformatf("L%0d rsp_rdata", L), ifc.rsp_rdata,      m_rdata);
                chk($sformatf("L%0d rsp_we", L),    32'(ifc.rsp_we),    32'(m_rwe));
                if (res_n) begin
                    if (act && age == L + 1) begin
                        m_rdata = m_we ? 32'd0 : ifc.bus_rdata;
                        m_rwe   = m_we;
                    end
                    if (act && age >= L + 2) begin
                        if (rsp_ready) begin
                            act = 0;
                            nrsp++;
                        end
                    end else if (!act && cmd_valid) begin
                        act     = 1;
                        age     = 0;
                        m_we    = cmd_we;
                        m_addr  = {cmd_addr[31:4], cmd_type, 2'b00};
                        m_wdata = cmd_wdata;
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] a, input logic [1:0] t,
                         input logic [31:0] d);
        step(1);
        cmd_valid = 1; cmd_we = we; cmd_addr = a; cmd_type = t; cmd_wdata = d;
        step(1);
        cmd_valid = 0; cmd_we = ~we; cmd_addr = $urandom; cmd_wdata = $urandom;
    endtask

    initial begin
        res_n = 0; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_type = 0; cmd_wdata = 0;
        rsp_ready = 1;
        step(3);
        res_n = 1;

        // directed: plain read, SET write, CLR write with low address bits set
        issue(1'b0, 32'h0000_0100, 2'b00, 32'h0);           step(22);
        issue(1'b1, 32'h0000_0110, 2'b01, 32'h0000_000F);   step(22);
        issue(1'b1, 32'h0000_1237, 2'b10, 32'h1234_5678);   step(22);
        step(1);
        chk("addr alias 0x1237/CLR", g_inst[0].ifc.bus_addr, 32'h0000_1238);

        // backpressure with a competing command held on the port
        rsp_ready = 0;
        issue(1'b0, 32'h0000_0200, 2'b11, 32'h0);
        cmd_valid = 1; cmd_we = 1; cmd_addr = 32'h0000_0300; cmd_wdata = 32'hDEAD_BEEF;
        step(30);
        rsp_ready = 1;
        step(1);
        cmd_valid = 0;
        step(25);

        // reset pulse while the longer-latency instances sit in WAIT
        issue(1'b0, 32'h0000_0400, 2'b00, 32'h0);
        step(1);
        res_n = 0;
        step(1);
        res_n = 1;
        step(20);

        // back-to-back reads, port always offering
        cmd_valid = 1; rsp_ready = 1; cmd_we = 0;
        for (int i = 0; i < 80; i++) begin
            cmd_addr = $urandom; cmd_type = 2'($urandom_range(0, 3));
            step(1);
        end
        cmd_valid = 0;
        step(25);

        // random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            res_n     = ($urandom_range(0, 199) != 0);
            cmd_valid = 1'($urandom_range(0, 1));
            rsp_ready = ($urandom_range(0, 4) != 0);
            cmd_we    = 1'($urandom_range(0, 1));
            cmd_addr  = $urandom;
            cmd_type  = 2'($urandom_range(0, 3));
            cmd_wdata = $urandom;
            step(1);
        end
        res_n = 1; cmd_valid = 0; rsp_ready = 1;
        step(40);

        chk("L1 responses seen",  32'(g_inst[0].nrsp > 10), 32'd1);
        chk("L2 responses seen",  32'(g_inst[1].nrsp > 10), 32'd1);
        chk("L3 responses seen",  32'(g_inst[2].nrsp > 10), 32'd1);
        chk("L15 responses seen", 32'(g_inst[3].nrsp > 10), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
